// File: rtl/spi_host.sv
// SPI mode-0 initiator issuing one 16-bit frame {addr, rw, data} per request
// to the spiMemory responder, returning read data with a one-cycle done pulse.
module spi_host #(
  parameter int HALF_PERIOD = 50
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       rw_i,
  input  logic [6:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       sclk_o,
  output logic       cs_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    GUARD,
    DONE
  } state_e;

  localparam logic [15:0] LastCnt = 16'(HALF_PERIOD - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bitIdx_q, bitIdx_d;
  logic        guardHalf_q, guardHalf_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  rxShift_q, rxShift_d;
  logic        rw_q, rw_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        sclk_q, sclk_d;
  logic        cs_q, cs_d;
  logic        lastCnt;

  assign lastCnt = (cnt_q == LastCnt);

  // Each phase lasts HALF_PERIOD cycles; GUARD runs two of them, tracked by guardHalf.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    bitIdx_d    = bitIdx_q;
    guardHalf_d = guardHalf_q;
    frame_d     = frame_q;
    rxShift_d   = rxShift_q;
    rw_d        = rw_q;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE, DONE: begin
        cnt_d       = '0;
        bitIdx_d    = '0;
        guardHalf_d = 1'b0;
        state_d     = IDLE;
        if (start_i) begin
          state_d   = LEAD;
          rw_d      = rw_i;
          frame_d   = {addr_i, rw_i, (rw_i ? 8'h00 : wdata_i)};
          rxShift_d = '0;
        end
      end
      LEAD: begin
        if (lastCnt) begin
          cnt_d   = '0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        // Data bits occupy rising edges 9..16; sample in the cycle sclk rises.
        if ((cnt_q == '0) && rw_q && bitIdx_q[3]) begin
          rxShift_d = {rxShift_q[6:0], miso_i};
        end
        if (lastCnt) begin
          cnt_d   = '0;
          state_d = LOW;
          frame_d = {frame_q[14:0], 1'b0};
        end
      end
      LOW: begin
        if (lastCnt) begin
          cnt_d = '0;
          if (bitIdx_q == 4'd15) begin
            state_d  = GUARD;
            bitIdx_d = '0;
          end else begin
            state_d  = HIGH;
            bitIdx_d = bitIdx_q + 4'd1;
          end
        end
      end
      GUARD: begin
        if (lastCnt) begin
          cnt_d = '0;
          if (guardHalf_q) begin
            state_d = DONE;
            if (rw_q) begin
              rdata_d = rxShift_q;
            end
          end else begin
            guardHalf_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin levels are registered from the next state so they never glitch.
  always_comb begin
    sclk_d = (state_d == HIGH);
    cs_d   = !((state_d == LEAD) || (state_d == HIGH) || (state_d == LOW));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitIdx_q    <= '0;
      guardHalf_q <= 1'b0;
      frame_q     <= '0;
      rxShift_q   <= '0;
      rw_q        <= 1'b0;
      rdata_q     <= '0;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitIdx_q    <= bitIdx_d;
      guardHalf_q <= guardHalf_d;
      frame_q     <= frame_d;
      rxShift_q   <= rxShift_d;
      rw_q        <= rw_d;
      rdata_q     <= rdata_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
    end
  end

  // The frame register shifts to zero after its last bit, so mosi idles low.
  assign mosi_o  = frame_q[15];
  assign sclk_o  = sclk_q;
  assign cs_o    = cs_q;
  assign rdata_o = rdata_q;
  assign busy_o  = (state_q == LEAD) || (state_q == HIGH) || (state_q == LOW) ||
                   (state_q == GUARD);
  assign done_o  = (state_q == DONE);

endmodule

// File: tb/tb_spi_host.sv
// Self-checking bench for spi_host: two instances (H=50 and H=8), each talking
// to a behavioural spiMemory responder, with a scoreboard checked at every done.
module tb_spi_host;

  localparam int H0 = 50;
  localparam int H1 = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       startW[2];
  logic       rwW[2];
  logic [6:0] addrW[2];
  logic [7:0] wdataW[2];
  logic       busyW[2];
  logic       doneW[2];
  logic [7:0] rdataW[2];
  logic       sclkW[2];
  logic       csW[2];
  logic       mosiW[2];

  int nChecks = 0;
  int nFail = 0;
  int cyc = 0;
  int doneCnt[2] = '{0, 0};

  typedef struct {
    int          inst;
    logic [15:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  exp_t       sbQ[$];
  logic [7:0] refMem[2][128];
  logic [7:0] lastRdata[2];
  int         riseQ[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic        miso = 1'b1;
    logic        prevS = 1'b0;
    int          rcnt = 0;
    logic [15:0] sh = '0;
    logic [7:0]  hdr = '0;
    logic [15:0] rxFrame = '0;
    logic [7:0]  mem[128];
    exp_t        e;

    spi_host #(.HALF_PERIOD(g == 0 ? H0 : H1)) u_dut (
      .clk_i  (clk),
      .reset_i(reset),
      .start_i(startW[g]),
      .rw_i   (rwW[g]),
      .addr_i (addrW[g]),
      .wdata_i(wdataW[g]),
      .busy_o (busyW[g]),
      .done_o (doneW[g]),
      .rdata_o(rdataW[g]),
      .sclk_o (sclkW[g]),
      .cs_o   (csW[g]),
      .mosi_o (mosiW[g]),
      .miso_i (miso)
    );

    // Responder: samples mosi after sclk rises, drives read data after sclk falls.
    always @(posedge clk) begin
      prevS <= sclkW[g];
      if (csW[g]) begin
        rcnt <= 0;
        miso <= 1'b1;
      end else begin
        if (sclkW[g] && !prevS) begin
          sh   <= {sh[14:0], mosiW[g]};
          rcnt <= rcnt + 1;
          if (rcnt == 7) hdr <= {sh[6:0], mosiW[g]};
          if (rcnt == 15) begin
            rxFrame <= {sh[14:0], mosiW[g]};
            if (!hdr[0]) mem[hdr[7:1]] <= {sh[6:0], mosiW[g]};
          end
        end
        if (!sclkW[g] && prevS && hdr[0] && (rcnt >= 8) && (rcnt < 16)) begin
          miso <= mem[hdr[7:1]][3'(15 - rcnt)];
        end
      end
    end

    // Scoreboard: every done must match the oldest outstanding request.
    always @(negedge clk) begin
      if (doneW[g]) begin
        doneCnt[g]++;
        checkOutput("sbNotEmpty", 32'(sbQ.size() != 0), 1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          checkOutput("sbInst", g, e.inst);
          checkOutput("sbFrame", rxFrame, e.frame);
          checkOutput("sbRdata", rdataW[g], e.rdata);
        end
      end
    end
  end

  logic prevN = 1'b0;
  always @(negedge clk) begin
    if (sclkW[0] && !prevN) riseQ.push_back(cyc);
    prevN = sclkW[0];
  end

  // Called at a negedge; holds start for exactly one sampling edge.
  task automatic applyStimulus(input int g, input logic rw, input logic [6:0] addr,
                               input logic [7:0] wdata, input bit expectDone);
    exp_t e;
    startW[g] = 1'b1;
    rwW[g]    = rw;
    addrW[g]  = addr;
    wdataW[g] = wdata;
    if (expectDone) begin
      e.inst  = g;
      e.frame = {addr, rw, (rw ? 8'h00 : wdata)};
      if (rw) begin
        e.rdata = refMem[g][addr];
      end else begin
        refMem[g][addr] = wdata;
        e.rdata = lastRdata[g];
      end
      lastRdata[g] = e.rdata;
      sbQ.push_back(e);
    end
    @(negedge clk);
    startW[g] = 1'b0;
  endtask

  task automatic waitDone(input int g, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (doneW[g]) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    checkOutput("doneSeen", 32'(at >= 0), 1);
  endtask

  task automatic waitCs(input int g, input logic level, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (csW[g] == level) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    checkOutput("csSeen", 32'(at >= 0), 1);
  endtask

  task automatic doXfer(input int g, input logic rw, input logic [6:0] addr,
                        input logic [7:0] wdata, output int t0, output int tDone);
    @(negedge clk);
    t0 = cyc;
    applyStimulus(g, rw, addr, wdata, 1'b1);
    waitDone(g, 4000, tDone);
  endtask

  int t0;
  int tA;
  int doneBase;

  initial begin
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      startW[g]    = 1'b0;
      rwW[g]       = 1'b0;
      addrW[g]     = '0;
      wdataW[g]    = '0;
      lastRdata[g] = 8'h00;
    end
    repeat (3) @(negedge clk);
    checkOutput("rstCs", csW[0], 1);
    checkOutput("rstSclk", sclkW[0], 0);
    checkOutput("rstMosi", mosiW[0], 0);
    checkOutput("rstBusy", busyW[0], 0);
    checkOutput("rstDone", doneW[0], 0);
    checkOutput("rstRdata", rdataW[0], 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Write 0x55 to addr 1 with full timing checks
    riseQ.delete();
    t0 = cyc;
    applyStimulus(0, 1'b0, 7'h01, 8'h55, 1'b1);
    waitCs(0, 1'b0, 10, tA);
    checkOutput("csFallCycle", tA, t0 + 1);
    checkOutput("busyAtCsFall", busyW[0], 1);
    waitCs(0, 1'b1, 4000, tA);
    checkOutput("csRiseCycle", tA, t0 + 1 + 33 * H0);
    waitDone(0, 4000, tA);
    checkOutput("doneCycle", tA, t0 + 1751);
    checkOutput("busyAtDone", busyW[0], 0);
    checkOutput("riseCount", riseQ.size(), 16);
    checkOutput("rise1Cycle", riseQ[0], t0 + 1 + H0);
    checkOutput("rise9Cycle", riseQ[8], t0 + 1 + 17 * H0);
    checkOutput("rise16Cycle", riseQ[15], t0 + 1 + 31 * H0);

    // Read back, overwrite with 0x00, read again
    doXfer(0, 1'b1, 7'h01, 8'h00, t0, tA);
    checkOutput("rdCycle", tA, t0 + 1751);
    doXfer(0, 1'b0, 7'h01, 8'h00, t0, tA);
    doXfer(0, 1'b1, 7'h01, 8'hFF, t0, tA);

    // Back-to-back: start accepted in the done cycle
    doXfer(0, 1'b0, 7'h7F, 8'hA3, t0, tA);
    applyStimulus(0, 1'b1, 7'h7F, 8'h00, 1'b1);
    checkOutput("b2bCsFall", csW[0], 0);
    checkOutput("b2bBusy", busyW[0], 1);
    waitDone(0, 4000, tA);

    // Start during a frame is ignored
    @(negedge clk);
    doneBase = doneCnt[0];
    riseQ.delete();
    t0 = cyc;
    applyStimulus(0, 1'b0, 7'h05, 8'h5A, 1'b1);
    repeat (199) @(negedge clk);
    startW[0] = 1'b1;
    rwW[0]    = 1'b1;
    addrW[0]  = 7'h01;
    @(negedge clk);
    startW[0] = 1'b0;
    waitDone(0, 4000, tA);
    checkOutput("ignDoneCycle", tA, t0 + 1751);
    checkOutput("ignRise16", riseQ[15], t0 + 1 + 31 * H0);
    repeat (2000) @(negedge clk);
    checkOutput("ignDoneCount", doneCnt[0] - doneBase, 1);

    // Reset during the 5th HIGH phase
    @(negedge clk);
    t0 = cyc;
    applyStimulus(0, 1'b0, 7'h10, 8'h99, 1'b0);
    repeat (9 * H0 + 1) @(negedge clk);
    checkOutput("at5thHigh", sclkW[0], 1);
    doneBase = doneCnt[0];
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midRstCs", csW[0], 1);
    checkOutput("midRstSclk", sclkW[0], 0);
    checkOutput("midRstMosi", mosiW[0], 0);
    checkOutput("midRstBusy", busyW[0], 0);
    checkOutput("midRstDone", doneW[0], 0);
    checkOutput("midRstRdata", rdataW[0], 8'h00);
    reset = 1'b0;
    lastRdata[0] = 8'h00;
    lastRdata[1] = 8'h00;
    repeat (2000) @(negedge clk);
    checkOutput("midRstNoDone", doneCnt[0] - doneBase, 0);
    doXfer(0, 1'b1, 7'h7F, 8'h00, t0, tA);
    doXfer(0, 1'b1, 7'h01, 8'h00, t0, tA);

    // Minimum half period instance
    doXfer(1, 1'b0, 7'h40, 8'h3C, t0, tA);
    checkOutput("h8DoneCycle", tA, t0 + 1 + 35 * H1);
    doXfer(1, 1'b1, 7'h40, 8'h00, t0, tA);
    checkOutput("h8Rdata", rdataW[1], 8'h3C);

    repeat (5) @(negedge clk);
    checkOutput("sbDrained", sbQ.size(), 0);

    $display("[TB] %0d/%0d checks passed", nChecks - nFail, nChecks);
    $finish;
  end

endmodule

// File: doc/spi_host.md
# spi_host

Single-transaction SPI initiator (mode 0, MSB first) that drives the `spiMemory` responder over its `sclk_pin`/`cs_pin`/`mosi_pin`/`miso_pin` interface. A local request port supplies a 7-bit address, a read/write flag and write data. The block generates one 16-bit frame: 7 address bits, 1 R/W bit (1 = read), then 8 data bits. It returns read data with a one-cycle `done` pulse. It sits on the board side as the bench/host driver replacing hand-timed stimulus.

## Interface
- `HALF_PERIOD`, default 50: clk cycles per sclk half-period. Legal range 8..65535; the minimum covers the responder's input-conditioner delay.
- `clk` in 1: system clock; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request strobe; sampled only while `busy`=0.
- `rw` in 1: 1 = read, 0 = write; captured with `start`.
- `addr` in 7: word address; captured with `start`.
- `wdata` in 8: write data; captured with `start`, ignored for reads.
- `busy` out 1: high while a frame or guard interval is in progress.
- `done` out 1: one-cycle pulse at transaction end.
- `rdata` out 8: read result; updated only at `done` of a read, held otherwise.
- `sclk` out 1: serial clock; idles low.
- `cs` out 1: chip select, active low; idles high.
- `mosi` out 1: serial data to responder; 0 whenever `cs`=1.
- `miso` in 1: serial data from responder; may be Z outside a read data phase.

## Operation
- Frame word F = {addr[6:0], rw, wdata[7:0]} for writes and {addr[6:0], rw, 8'h00} for reads; shifted out MSB (F[15]) first.
- States: IDLE, LEAD, HIGH, LOW, GUARD, DONE. A 16-bit half-period counter and a 4-bit bit index are kept.
- IDLE: `cs`=1, `sclk`=0, `mosi`=0. On `start`=1, latch `addr`, `rw` and `wdata`, then go to LEAD.
- LEAD (HALF_PERIOD cycles): `cs`=0, `mosi`=F[15], `sclk`=0. Then go to HIGH.
- HIGH (HALF_PERIOD cycles): `sclk`=1. The responder samples `mosi` on this rising edge. Then go to LOW.
- LOW (HALF_PERIOD cycles): `sclk`=0.
  - On the first LOW cycle, `mosi` advances to the next bit. After bit 0 it returns to 0.
  - After the 16th LOW, go to GUARD. Otherwise go to HIGH with the bit index incremented.
- Read capture: for bits 7..0 (the 9th..16th rising edges), `miso` is sampled in the cycle `sclk` goes 0→1 and shifted into a read shift register LSB-in. The responder changes `miso` on sclk falling edges, so the sample is at least HALF_PERIOD−conditioner-delay cycles after the change.
- GUARD (2*HALF_PERIOD cycles): `cs`=1, `sclk`=0, `mosi`=0. This lets the responder FSM return to idle.
- DONE (1 cycle): `done`=1, `busy`=0. If `rw`=1, `rdata` takes the shift register value. Then go to IDLE.
  - `start` in the DONE cycle is accepted, giving back-to-back frames.
- `start` while `busy`=1 is ignored; no queuing.
- Writes never modify `rdata`; Z on `miso` never reaches `rdata`.

## Timing
- Reset values: `sclk`=0, `cs`=1, `mosi`=0, `busy`=0, `done`=0, `rdata`=8'h00, state IDLE, counters 0.
- Let H = HALF_PERIOD, with `start` sampled at cycle 0.
  - `cs` falls at cycle 1, with `busy`=1 from the same cycle.
  - Rising edge k (k=1..16) occurs at cycle 1+H+2H(k−1).
  - `cs` rises at cycle 1+33H.
  - `done` pulses at cycle 1+35H; `busy` is low in that cycle.
- `mosi` is stable for ≥H cycles before and H cycles after every rising edge it is sampled on.
- `cs` low time is exactly 33H cycles; minimum `cs` high time between frames is 2H+1 cycles.
- Reset mid-frame: in the next cycle `cs`=1, `sclk`=0 and `mosi`=0, with no `done` pulse. `rdata` clears to 0. The responder aborts on the `cs` rise.
- Reset asserted together with `start` wins.

## Test plan
- Write 0x55 to addr 1, H=50: `mosi` at the 16 rising edges reads 0000001_0_01010101. `cs` is low for exactly 1650 cycles; `done` fires at cycle 1751; `rdata` stays 0x00.
- Write 0x55 to addr 1, then read addr 1 against `spiMemory`: the read frame's first byte is 0x03, and `rdata`=0x55 at `done`. Then write 0x00 and read again: `rdata`=0x00.
- Read addr 0x7F after writing 0xA3 there, with `start` pulsed in the first write's `done` cycle: the second frame's `cs` falls one cycle after that `done`, and the read returns 0xA3.
- `start` pulsed at cycle 200 during a frame: ignored. Exactly one `done` occurs, and edge timing is unchanged.
- `reset` at the 5th HIGH: next cycle `cs`=1, `sclk`=0, `busy`=0, no `done`. A subsequent read of a previously written address returns the correct data.
- H=8 parameter build: a write then read of 0x3C at addr 0x40 round-trips correctly against `spiMemory`.
